// File: rtl/alt_enable_pkg.sv
// ============================================================================
// alt_enable_pkg : shared RAM/width defaults and FSM state type for alt_enable.
// Revision 1.0
// ============================================================================
`default_nettype none

`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

package alt_enable_pkg;

    localparam int ALT_STATE_W = 3;

    typedef logic [ALT_STATE_W-1:0] alt_state_t;

endpackage

`default_nettype wire

// File: rtl/alt_enable.sv
// ============================================================================
// alt_enable : serial enable of an alternation set against a single-port RAM.
// Optional feature: define ALT_GUARD_EN to add the per-entry guardMask port.
// Revision 1.0
// ============================================================================
`default_nettype none

module alt_enable
    import alt_enable_pkg::*;
#(
    parameter int addrBits    = `ADDRESS_BITS,
    parameter int dataBits    = `DATA_BITS,
    parameter int maxChannels = 8,
    localparam int idxBits    = $clog2(maxChannels + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addrBits-1:0]    listBase,
    input  logic [idxBits-1:0]     count,
    input  logic [addrBits-1:0]    rxPid,
`ifdef ALT_GUARD_EN
    input  logic [maxChannels-1:0] guardMask,
`endif
    output logic                   finished,
    output logic                   busy,
    output logic                   rxCanReceive,
    output logic [idxBits-1:0]     readyIndex,
    output logic [addrBits-1:0]    address,
    output logic                   readWriteMode,
    output logic [dataBits-1:0]    dataIn,
    input  logic [dataBits-1:0]    dataOut
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_DECIDE  = 3'd4;
    localparam logic [2:0] S_WRITE_0 = 3'd5;
    localparam logic [2:0] S_WRITE_1 = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    alt_state_t            state_q,        state_d;
    logic [addrBits-1:0]   listBase_q,     listBase_d;
    logic [idxBits-1:0]    count_q,        count_d;
    logic [addrBits-1:0]   rxPid_q,        rxPid_d;
    logic [idxBits-1:0]    i_q,            i_d;
    logic [addrBits-1:0]   channel_q,      channel_d;
    logic [dataBits-1:0]   tx_q,           tx_d;
    logic                  rxCanReceive_q, rxCanReceive_d;
    logic [idxBits-1:0]    readyIndex_q,   readyIndex_d;

    logic [idxBits-1:0]    iNext;
    logic                  entryEnabled;

    assign iNext = i_q + idxBits'(1);

`ifdef ALT_GUARD_EN
    logic [maxChannels-1:0] guard_q, guard_d;
    logic [maxChannels-1:0] guardShifted;

    assign guardShifted = guard_q >> i_q;
    assign entryEnabled = guardShifted[0];
`else
    assign entryEnabled = 1'b1;
`endif

    always_comb begin
        state_d        = state_q;
        listBase_d     = listBase_q;
        count_d        = count_q;
        rxPid_d        = rxPid_q;
        i_d            = i_q;
        channel_d      = channel_q;
        tx_d           = tx_q;
        rxCanReceive_d = rxCanReceive_q;
        readyIndex_d   = readyIndex_q;
`ifdef ALT_GUARD_EN
        guard_d        = guard_q;
`endif
        address        = '0;
        readWriteMode  = `RAM_READ;
        dataIn         = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    listBase_d     = listBase;
                    count_d        = count;
                    rxPid_d        = rxPid;
`ifdef ALT_GUARD_EN
                    guard_d        = guardMask;
`endif
                    i_d            = '0;
                    rxCanReceive_d = 1'b0;
                    readyIndex_d   = '0;
                    state_d        = (count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (entryEnabled) begin
                    address = listBase_q + addrBits'(i_q);
                    state_d = S_LATCH;
                end else begin
                    // Guarded-off entry: skip without touching the RAM
                    i_d     = iNext;
                    state_d = (iNext < count_q) ? S_FETCH : S_DONE;
                end
            end
            S_LATCH: begin
                channel_d = dataOut[addrBits-1:0];
                address   = dataOut[addrBits-1:0];
                state_d   = S_READ;
            end
            S_READ: begin
                address = channel_q;
                tx_d    = dataOut;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                address = channel_q;
                if (tx_q != '0) begin
                    rxCanReceive_d = 1'b1;
                    readyIndex_d   = i_q;
                    state_d        = S_DONE;
                end else begin
                    state_d        = S_WRITE_0;
                end
            end
            S_WRITE_0: begin
                address       = channel_q;
                readWriteMode = `RAM_WRITE;
                dataIn        = dataBits'(rxPid_q);
                state_d       = S_WRITE_1;
            end
            S_WRITE_1: begin
                address       = channel_q;
                readWriteMode = `RAM_WRITE;
                dataIn        = dataBits'(rxPid_q);
                i_d           = iNext;
                state_d       = (iNext < count_q) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            listBase_q     <= '0;
            count_q        <= '0;
            rxPid_q        <= '0;
            i_q            <= '0;
            channel_q      <= '0;
            tx_q           <= '0;
            rxCanReceive_q <= 1'b0;
            readyIndex_q   <= '0;
`ifdef ALT_GUARD_EN
            guard_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            listBase_q     <= listBase_d;
            count_q        <= count_d;
            rxPid_q        <= rxPid_d;
            i_q            <= i_d;
            channel_q      <= channel_d;
            tx_q           <= tx_d;
            rxCanReceive_q <= rxCanReceive_d;
            readyIndex_q   <= readyIndex_d;
`ifdef ALT_GUARD_EN
            guard_q        <= guard_d;
`endif
        end
    end

    assign finished     = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign rxCanReceive = rxCanReceive_q;
    assign readyIndex   = readyIndex_q;

endmodule

`default_nettype wire

// File: tb/tb_alt_enable.sv
// ============================================================================
// tb_alt_enable : directed self-checking bench for alt_enable with a RAM model.
// Revision 1.0
// ============================================================================
`default_nettype none

`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module tb_alt_enable;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  listBase;
    logic [3:0]  count;
    logic [7:0]  rxPid;
    logic [7:0]  guardMask;
    logic        finished;
    logic        busy;
    logic        rxCanReceive;
    logic [3:0]  readyIndex;
    logic [7:0]  address;
    logic        readWriteMode;
    logic [15:0] dataIn;
    logic [15:0] dataOut;

    logic [15:0] mem [256];
    logic        preClear;
    logic        preWe;
    logic [7:0]  preAddr;
    logic [15:0] preData;
    logic [7:0]  wAddr [64];
    logic [15:0] wData [64];
    int          wCount;

    int checks = 0;
    int errors = 0;

    alt_enable #(
        .addrBits    (8),
        .dataBits    (16),
        .maxChannels (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .listBase      (listBase),
        .count         (count),
        .rxPid         (rxPid),
`ifdef ALT_GUARD_EN
        .guardMask     (guardMask),
`endif
        .finished      (finished),
        .busy          (busy),
        .rxCanReceive  (rxCanReceive),
        .readyIndex    (readyIndex),
        .address       (address),
        .readWriteMode (readWriteMode),
        .dataIn        (dataIn),
        .dataOut       (dataOut)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM plus a log of every write cycle
    always @(posedge clk) begin
        dataOut <= mem[address];
        if (preClear) begin
            for (int k = 0; k < 256; k++) mem[k] = '0;
            wCount = 0;
        end else if (preWe) begin
            mem[preAddr] = preData;
        end else if (readWriteMode == `RAM_WRITE) begin
            mem[address] = dataIn;
            if (wCount < 64) begin
                wAddr[wCount] = address;
                wData[wCount] = dataIn;
            end
            wCount = wCount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        @(negedge clk) preClear = 1'b1;
        @(negedge clk) preClear = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        preAddr = a;
        preData = d;
        preWe   = 1'b1;
        @(negedge clk) preWe = 1'b0;
    endtask

    task automatic setup_list();
        poke(8'h40, 16'h0010);
        poke(8'h41, 16'h0011);
        poke(8'h42, 16'h0012);
    endtask

    task automatic run_set(input logic [7:0] base, input logic [3:0] cnt, input logic [7:0] gm,
                           input int busyPoke, output int cyc);
        @(negedge clk);
        listBase  = base;
        count     = cnt;
        rxPid     = 8'h05;
        guardMask = gm;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!finished && cyc < 200) begin
            if (cyc == busyPoke) begin
                start = 1'b1;
                count = 4'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [7:0] a0,
                                input logic [7:0] a1, input logic [7:0] a2);
        logic [7:0] ea [3];
        ea[0] = a0;
        ea[1] = a1;
        ea[2] = a2;
        check({tag, "_wcount"}, wCount, 2 * n);
        for (int k = 0; k < 2 * n && k < 6; k++) begin
            check({tag, "_waddr"}, wAddr[k], ea[k/2]);
            check({tag, "_wdata"}, wData[k], 32'h0005);
        end
    endtask

    initial begin
        int cyc;
        int bound;
        reset     = 1'b1;
        start     = 1'b0;
        listBase  = '0;
        count     = '0;
        rxPid     = '0;
        guardMask = 8'hFF;
        preClear  = 1'b0;
        preWe     = 1'b0;
        preAddr   = '0;
        preData   = '0;
        wCount    = 0;

        #2 reset = 1'b0;
        #1;
        check("rst_finished", finished, 0);
        check("rst_busy", busy, 0);
        check("rst_rx", rxCanReceive, 0);
        check("rst_idx", readyIndex, 0);
        check("rst_mode", readWriteMode, `RAM_READ);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Empty set
        clear_mem();
        run_set(8'h40, 4'd0, 8'hFF, 0, cyc);
        check("c0_cycles", cyc, 1);
        check("c0_rx", rxCanReceive, 0);
        check("c0_writes", wCount, 0);
        @(negedge clk);
        check("c0_idle", busy, 0);

        // Three idle channels: every one gets the receiver pid
        clear_mem();
        setup_list();
        run_set(8'h40, 4'd3, 8'hFF, 0, cyc);
        check("all_cycles", cyc, 19);
        check("all_rx", rxCanReceive, 0);
        check_writes("all", 3, 8'h10, 8'h11, 8'h12);

        // Second channel already has a sender: early exit
        clear_mem();
        setup_list();
        poke(8'h11, 16'h0007);
        run_set(8'h40, 4'd3, 8'hFF, 0, cyc);
        check("rdy_cycles", cyc, 11);
        check("rdy_rx", rxCanReceive, 1);
        check("rdy_idx", readyIndex, 1);
        check_writes("rdy", 1, 8'h10, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("rdy_hold_rx", rxCanReceive, 1);
        check("rdy_hold_idx", readyIndex, 1);
        run_set(8'h40, 4'd0, 8'hFF, 0, cyc);
        check("rdy_clr_rx", rxCanReceive, 0);
        check("rdy_clr_idx", readyIndex, 0);

`ifdef ALT_GUARD_EN
        clear_mem();
        setup_list();
        run_set(8'h40, 4'd3, 8'b0000_0101, 0, cyc);
        check("grd_cycles", cyc, 14);
        check("grd_rx", rxCanReceive, 0);
        check_writes("grd", 2, 8'h10, 8'h12, 8'h00);
        guardMask = 8'hFF;
`endif

        // Reset asserted while the first write is in progress
        clear_mem();
        setup_list();
        @(negedge clk);
        listBase = 8'h40;
        count    = 4'd3;
        rxPid    = 8'h05;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bound = 0;
        while (readWriteMode != `RAM_WRITE && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        check("mid_reached_write", readWriteMode, `RAM_WRITE);
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_finished", finished, 0);
        check("mid_mode", readWriteMode, `RAM_READ);
        check("mid_rx", rxCanReceive, 0);
        check("mid_idx", readyIndex, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_noresume", busy, 0);
        check("mid_nowrite", wCount, 0);
        clear_mem();
        setup_list();
        run_set(8'h40, 4'd3, 8'hFF, 0, cyc);
        check("mid_fresh_cycles", cyc, 19);
        check_writes("mid_fresh", 3, 8'h10, 8'h11, 8'h12);

        // List wraps past the top of memory; a start while busy is ignored
        clear_mem();
        poke(8'hFF, 16'h0020);
        poke(8'h00, 16'h0021);
        run_set(8'hFF, 4'd2, 8'hFF, 3, cyc);
        check("wrap_cycles", cyc, 13);
        check_writes("wrap", 2, 8'h20, 8'h21, 8'h00);
        @(negedge clk);
        check("wrap_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
